and_gate_vec_checker: RTL and testbench
=======================================

Name: and_gate_vec_checker

Overview:
- Self-sequencing stimulus/response block for a 2-input AND gate or primitive under test.
- Drives the a/b inputs of the gate through a fixed vector set and samples the gate output after a programmable settle time.
- Compares each sample against the AND truth table and reports a mismatch count plus a pass/fail verdict.
- Sits on the bench side, opposite the gate: this block produces stimulus and consumes y.

Parameters:
- SETTLE, 2, cycles waited after driving a vector before y_in is sampled (legal range 1..15).
- LOOPS, 1, number of full passes over the vector set per start (legal range 1..255).
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- y_in  input  1  output of the gate under test.
- a_out  output  1  gate input a.
- b_out  output  1  gate input b.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next start.
- err_cnt  output  CNT_W  mismatches in the current or last run; saturates at all-ones.
- vec_idx  output  4  index of the vector currently driven.

Behaviour:
- Reset values (rst high at posedge): state IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0; settle counter and loop counter cleared.
- Reset has priority over every other input.
- Reset mid-run aborts the run: no done pulse, and pass stays 0.
- Base vector set, indexed 0..3: (a,b) = 00, 01, 10, 11. Expected y = 0, 0, 0, 1.
- NV = 4.
- FSM states:
  - IDLE: if start, clear err_cnt, vec_idx and loop counter, then go to DRIVE.
  - DRIVE: register a_out/b_out from vector[vec_idx], load the settle counter with SETTLE, then go to WAIT.
  - WAIT: decrement the settle counter; go to SAMPLE when it reaches 1.
  - SAMPLE: compare y_in with the expected value. On mismatch, increment err_cnt unless it is all-ones.
    - If vec_idx < NV-1: vec_idx++ and go to DRIVE.
    - Else if loop counter < LOOPS-1: loop++, vec_idx=0, go to DRIVE.
    - Else go to DONE.
  - DONE: done=1 for exactly this cycle; pass = (err_cnt==0), including a mismatch found in the final SAMPLE. Then go to IDLE.
- a_out/b_out hold their last value in IDLE and DONE.
- Timing:
  - Each vector costs SETTLE+1 cycles: DRIVE 1, WAIT SETTLE-1, SAMPLE 1.
  - If start is sampled at cycle 0, done is high in cycle 1 + LOOPS*NV*(SETTLE+1).
  - With defaults, done is high in cycle 13.
- busy is high in DRIVE, WAIT, SAMPLE and DONE; it is low in IDLE.
- start while busy is ignored, with no restart and no counter clear.
- start coincident with the DONE cycle is ignored.
- Comparison uses case equality (===), so a y_in of z or x counts as a mismatch against a 0/1 expectation.

Optional Feature:
- Macro: AND_VEC_CHK_XPROP_EN.
- Defined:
  - NV = 9 and vec_idx covers 0..8.
  - Five extra 4-state vectors are appended:
    - (0,x) expects 0
    - (x,0) expects 0
    - (x,1) expects x
    - (1,x) expects x
    - (x,x) expects x
  - All comparisons use ===.
  - This build is simulation-only.
- Not defined:
  - Only the 4 binary vectors are used and NV = 4.
  - The logic is fully synthesizable, with no x literals in the RTL.

Test Plan:
1. Correct AND DUT, defaults, start pulsed at cycle 0 -> done pulse at cycle 13, pass=1, err_cnt=0, a_out/b_out sequence 00,01,10,11.
2. y_in tied to 1 -> done at cycle 13, err_cnt=3, pass=0.
3. CNT_W=2, LOOPS=2, y_in tied to 1 -> 6 raw mismatches; err_cnt saturates at 3, pass=0, done at cycle 25.
4. start re-pulsed at cycles 4 and 12 during a run -> no restart, done still at cycle 13, err_cnt unaffected.
5. rst asserted at cycle 6 mid-run -> next cycle busy=0, a_out=b_out=0, err_cnt=0, no done pulse; a fresh start completes normally.
6. AND_VEC_CHK_XPROP_EN defined, gate modelled with built-in and -> 9 vectors, done at cycle 28, pass=1. Forcing y_in to 0 on vector (x,1) -> err_cnt=1.

Source files
------------

// File: rtl/and_gate_vec_checker_if.sv
// and_gate_vec_checker_if: control/status and gate-side signals of the checker.
// slave is the checker side, master is the controller and gate side.
interface and_gate_vec_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             y_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       vec_idx;

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_cnt, vec_idx
  );

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_cnt, vec_idx
  );
endinterface

// File: rtl/and_gate_vec_checker.sv
// and_gate_vec_checker: walks the AND vector set, samples y_in, counts misses.
// Define AND_VEC_CHK_XPROP_EN to append 4-state vectors (simulation only).
module and_gate_vec_checker #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1,
  parameter int CNT_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  and_gate_vec_checker_if.slave bus
);

`ifdef AND_VEC_CHK_XPROP_EN
  localparam int NV = 9;
`else
  localparam int NV = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           st;
  state_t           nxt;
  logic             a_q;
  logic             b_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       vec_q;
  logic [3:0]       set_q;
  logic [7:0]       loop_q;
  logic             a_v;
  logic             b_v;
  logic             exp_v;
  logic             mis;
  logic             last_vec;
  logic             last_loop;

  // Vector table: binary entries come from the index bits.
  always_comb begin
    a_v   = vec_q[1];
    b_v   = vec_q[0];
    exp_v = vec_q[1] & vec_q[0];
`ifdef AND_VEC_CHK_XPROP_EN
    unique case (vec_q)
      4'd4: begin a_v = 1'b0; b_v = 1'bx; exp_v = 1'b0; end
      4'd5: begin a_v = 1'bx; b_v = 1'b0; exp_v = 1'b0; end
      4'd6: begin a_v = 1'bx; b_v = 1'b1; exp_v = 1'bx; end
      4'd7: begin a_v = 1'b1; b_v = 1'bx; exp_v = 1'bx; end
      4'd8: begin a_v = 1'bx; b_v = 1'bx; exp_v = 1'bx; end
      default: ;
    endcase
`endif
  end

  // Case-equality compare so x/z on y_in count as misses.
  always_comb begin
    mis       = (bus.y_in !== exp_v);
    last_vec  = (vec_q == 4'(NV - 1));
    last_loop = (loop_q == 8'(LOOPS - 1));
    err_nxt   = err_q;
    if (mis && (err_q != '1)) err_nxt = err_q + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  // Next-state logic; SETTLE of 1 skips WAIT entirely.
  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   if (bus.start) nxt = S_DRIVE;
      S_DRIVE:  nxt = (SETTLE == 1) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (set_q <= 4'd2) nxt = S_SAMPLE;
      S_SAMPLE: nxt = (last_vec && last_loop) ? S_DONE : S_DRIVE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Datapath: stimulus, settle/loop counters, mismatch count, verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      vec_q  <= 4'd0;
      set_q  <= 4'd0;
      loop_q <= 8'd0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (bus.start) begin
            err_q  <= '0;
            vec_q  <= 4'd0;
            loop_q <= 8'd0;
            pass_q <= 1'b0;
          end
        end
        S_DRIVE: begin
          a_q   <= a_v;
          b_q   <= b_v;
          set_q <= 4'(SETTLE);
        end
        S_WAIT: begin
          set_q <= set_q - 4'd1;
        end
        S_SAMPLE: begin
          err_q <= err_nxt;
          if (!last_vec) begin
            vec_q <= vec_q + 4'd1;
          end else if (!last_loop) begin
            loop_q <= loop_q + 8'd1;
            vec_q  <= 4'd0;
          end else begin
            pass_q <= (err_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    bus.busy    = (st != S_IDLE);
    bus.done    = (st == S_DONE);
    bus.a_out   = a_q;
    bus.b_out   = b_q;
    bus.pass    = pass_q;
    bus.err_cnt = err_q;
    bus.vec_idx = vec_q;
  end

endmodule

// File: tb/tb_and_gate_vec_checker.sv
// tb_and_gate_vec_checker: directed checks of timing, counting and reset.
// Build with AND_VEC_CHK_XPROP_EN to also cover the 4-state vectors.
module tb_and_gate_vec_checker;

`ifdef AND_VEC_CHK_XPROP_EN
  localparam int NV = 9;
`else
  localparam int NV = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y_stuck = 1'b0;
  logic y_force = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  and_gate_vec_checker_if #(.CNT_W(8)) if0 ();
  and_gate_vec_checker_if #(.CNT_W(2)) if1 ();

  and_gate_vec_checker #(.SETTLE(2), .LOOPS(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  and_gate_vec_checker #(.SETTLE(2), .LOOPS(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  assign if0.y_in = y_stuck ? 1'b1 :
                    (y_force && if0.vec_idx == 4'd6) ? 1'b0 :
                    (if0.a_out & if0.b_out);
  assign if1.y_in = 1'b1;

  int         d_cyc;
  int         d_num;
  logic [1:0] ab_rec [NV];
  logic [3:0] vi_rec [NV];
  logic [7:0] e_done;
  logic       p_done;
  logic       b_c1;
  logic       b_after;
  logic [7:0] e_pre;
  logic       b_rst;
  logic       a_rst;
  logic       bb_rst;
  logic [7:0] e_rst;

  task automatic run0(input bit repulse, input int rst_at, input int limit);
    d_cyc = 0;
    d_num = 0;
    b_after = 1'bx;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (c == 1) b_c1 = if0.busy;
      for (int k = 0; k < NV; k++)
        if (c == 3 + 3 * k) begin
          ab_rec[k] = {if0.a_out, if0.b_out};
          vi_rec[k] = if0.vec_idx;
        end
      if (if0.done === 1'b1) begin
        d_num++;
        if (d_cyc == 0) begin
          d_cyc  = c;
          e_done = if0.err_cnt;
          p_done = if0.pass;
        end
      end
      if (d_cyc != 0 && c == d_cyc + 1) b_after = if0.busy;
      if (rst_at != 0 && c == rst_at + 1) begin
        b_rst  = if0.busy;
        a_rst  = if0.a_out;
        bb_rst = if0.b_out;
        e_rst  = if0.err_cnt;
      end
      if (rst_at != 0 && c == rst_at) begin
        e_pre = if0.err_cnt;
        rst   = 1'b1;
      end
      if0.start = repulse && (c == 4 || c == 12 || c == 13);
      @(posedge clk); #1;
      rst = 1'b0;
    end
    if0.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({if0.busy, if0.done, if0.pass} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {if0.busy, if0.done, if0.pass});
    end
    n_chk++;
    if ({if0.a_out, if0.b_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ab: got %b want 00", {if0.a_out, if0.b_out});
    end
    n_chk++;
    if (if0.err_cnt !== 8'd0 || if0.vec_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got err %0h idx %0h want 0 0", if0.err_cnt, if0.vec_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    y_stuck = 1'b0;
    run0(1'b0, 0, 20);
    n_chk++;
    if (b_c1 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_c1: got %b want 1", b_c1);
    end
    n_chk++;
    if (d_cyc != 13 || d_num != 1) begin
      n_fail++;
      $display("FAIL basic_done: got cyc %0d pulses %0d want 13 1", d_cyc, d_num);
    end
    n_chk++;
    if (p_done !== 1'b1 || e_done !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_verdict: got pass %b err %0d want 1 0", p_done, e_done);
    end
    n_chk++;
    if ({ab_rec[0], ab_rec[1], ab_rec[2], ab_rec[3]} !== 8'b00_01_10_11) begin
      n_fail++;
      $display("FAIL basic_ab_seq: got %b%b%b%b want 00011011",
               ab_rec[0], ab_rec[1], ab_rec[2], ab_rec[3]);
    end
    n_chk++;
    if ({vi_rec[0], vi_rec[1], vi_rec[2], vi_rec[3]} !== 16'h0123) begin
      n_fail++;
      $display("FAIL basic_vec_idx: got %h%h%h%h want 0123",
               vi_rec[0], vi_rec[1], vi_rec[2], vi_rec[3]);
    end
    n_chk++;
    if (b_after !== 1'b0 || if0.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after: got busy %b pass %b want 0 1", b_after, if0.pass);
    end
  endtask

  task automatic test_stuck_high();
    y_stuck = 1'b1;
    run0(1'b0, 0, 20);
    y_stuck = 1'b0;
    n_chk++;
    if (d_cyc != 13) begin
      n_fail++;
      $display("FAIL stuck_done: got cyc %0d want 13", d_cyc);
    end
    n_chk++;
    if (e_done !== 8'd3 || p_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_verdict: got err %0d pass %b want 3 0", e_done, p_done);
    end
  endtask

  task automatic test_saturate();
    int         dc;
    int         np;
    logic [1:0] e7;
    logic [1:0] ed;
    logic       pd;
    dc = 0;
    np = 0;
    e7 = 2'bxx;
    ed = 2'bxx;
    pd = 1'bx;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 7) e7 = if1.err_cnt;
      if (if1.done === 1'b1) begin
        np++;
        if (dc == 0) begin
          dc = c;
          ed = if1.err_cnt;
          pd = if1.pass;
        end
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (e7 !== 2'd2) begin
      n_fail++;
      $display("FAIL sat_partial: got err %0d want 2", e7);
    end
    n_chk++;
    if (dc != 25 || np != 1) begin
      n_fail++;
      $display("FAIL sat_done: got cyc %0d pulses %0d want 25 1", dc, np);
    end
    n_chk++;
    if (ed !== 2'd3 || pd !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_verdict: got err %0d pass %b want 3 0", ed, pd);
    end
  endtask

  task automatic test_back_to_back();
    run0(1'b1, 0, 20);
    n_chk++;
    if (d_cyc != 13 || d_num != 1) begin
      n_fail++;
      $display("FAIL b2b_done: got cyc %0d pulses %0d want 13 1", d_cyc, d_num);
    end
    n_chk++;
    if (e_done !== 8'd0 || p_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_verdict: got err %0d pass %b want 0 1", e_done, p_done);
    end
    n_chk++;
    if (b_after !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_start: got busy %b want 0", b_after);
    end
  endtask

  task automatic test_mid_reset();
    y_stuck = 1'b1;
    run0(1'b0, 6, 30);
    y_stuck = 1'b0;
    n_chk++;
    if (e_pre !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_pre_err: got %0d want 1", e_pre);
    end
    n_chk++;
    if ({b_rst, a_rst, bb_rst} !== 3'b000 || e_rst !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_abort: got busy %b a %b b %b err %0d want 0 0 0 0",
               b_rst, a_rst, bb_rst, e_rst);
    end
    n_chk++;
    if (d_num != 0 || if0.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_done: got pulses %0d pass %b want 0 0", d_num, if0.pass);
    end
    run0(1'b0, 0, 20);
    n_chk++;
    if (d_cyc != 13 || p_done !== 1'b1 || e_done !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_rerun: got cyc %0d pass %b err %0d want 13 1 0",
               d_cyc, p_done, e_done);
    end
  endtask

`ifdef AND_VEC_CHK_XPROP_EN
  task automatic test_xprop();
    y_force = 1'b0;
    run0(1'b0, 0, 35);
    n_chk++;
    if (d_cyc != 28 || p_done !== 1'b1 || e_done !== 8'd0) begin
      n_fail++;
      $display("FAIL xp_clean: got cyc %0d pass %b err %0d want 28 1 0",
               d_cyc, p_done, e_done);
    end
    n_chk++;
    if (ab_rec[4] !== 2'b0x || ab_rec[6] !== 2'bx1 || ab_rec[8] !== 2'bxx) begin
      n_fail++;
      $display("FAIL xp_ab: got %b %b %b want 0x x1 xx", ab_rec[4], ab_rec[6], ab_rec[8]);
    end
    y_force = 1'b1;
    run0(1'b0, 0, 35);
    y_force = 1'b0;
    n_chk++;
    if (d_cyc != 28 || p_done !== 1'b0 || e_done !== 8'd1) begin
      n_fail++;
      $display("FAIL xp_forced: got cyc %0d pass %b err %0d want 28 0 1",
               d_cyc, p_done, e_done);
    end
  endtask
`endif

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    test_reset();
    test_basic();
    test_stuck_high();
    test_saturate();
    test_back_to_back();
    test_mid_reset();
`ifdef AND_VEC_CHK_XPROP_EN
    test_xprop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
